// File: rtl/fig8_seg_monitor_pkg.sv
// Shared constants, state types and the pattern decoder for the figure-eight segment monitor.
// Latency: none (types, constants and a combinational helper only).
// Backpressure: not applicable.
package fig8_pkg;

  // Segment bit positions as one-hot patterns (active-high after inversion)
  localparam logic [7:0] SEG_A  = 8'h01;
  localparam logic [7:0] SEG_B  = 8'h02;
  localparam logic [7:0] SEG_C  = 8'h04;
  localparam logic [7:0] SEG_D  = 8'h08;
  localparam logic [7:0] SEG_E  = 8'h10;
  localparam logic [7:0] SEG_F  = 8'h20;
  localparam logic [7:0] SEG_G  = 8'h40;
  localparam logic [7:0] SEG_DP = 8'h80;

  localparam logic [7:0] BLANK_PAT = 8'h00;

  // Figure-eight order a,b,g,e,d,c,g,f; g appears twice, so it is resolved by context
  localparam logic [7:0] FIG8_SEQ [8] = '{SEG_A, SEG_B, SEG_G, SEG_E, SEG_D, SEG_C, SEG_G, SEG_F};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ANCHOR = 2'd1,
    LOCKED = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    PAT_STEP    = 2'd0,  // decodes to a step index
    PAT_BAD_G   = 2'd1,  // g with no disambiguating predecessor
    PAT_BLANK   = 2'd2,  // all segments off
    PAT_INVALID = 2'd3   // multi-bit or dp
  } pat_kind_t;

  typedef struct packed {
    pat_kind_t  kind;
    logic [2:0] idx;
  } decode_t;

  // Classify an accepted pattern; prev_idx decides which half of the eight a g belongs to
  function automatic decode_t decode_pat(input logic [7:0] pat, input logic [2:0] prev_idx);
    decode_t d;
    d.kind = PAT_INVALID;
    d.idx  = 3'd0;
    if (pat == BLANK_PAT) begin
      d.kind = PAT_BLANK;
    end else if (pat == SEG_G) begin
      if (prev_idx == 3'd1) begin
        d.kind = PAT_STEP;
        d.idx  = 3'd2;
      end else if (prev_idx == 3'd5) begin
        d.kind = PAT_STEP;
        d.idx  = 3'd6;
      end else begin
        d.kind = PAT_BAD_G;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (pat == FIG8_SEQ[i]) begin
          d.kind = PAT_STEP;
          d.idx  = 3'(i);
        end
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/fig8_seg_monitor_seg_input_filter.sv
// Synchronizes the active-low segment lines, inverts them and accepts a pattern once it is stable.
// Latency: seg_n settled before edge k -> accept high after edge k+1+STABLE_CYCLES.
// Backpressure: none; the input is sampled every cycle and accept is a single-cycle strobe.
module seg_input_filter
  import fig8_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] seg_n,
  output logic [7:0] pattern,
  output logic       accept
);

  localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

  logic [7:0] sync1;
  logic [7:0] sync2;
  logic [7:0] seg;
  logic [7:0] cand;
  logic [3:0] cnt;
  logic [3:0] cnt_next;

  assign seg = ~sync2;

  // Count consecutive cycles seg has matched the candidate; any change restarts at one
  always_comb begin
    cnt_next = cnt;
    if (seg != cand) begin
      cnt_next = 4'd1;
    end else if (cnt != STABLE) begin
      cnt_next = cnt + 4'd1;
    end
  end

  // Synchronizer, candidate tracking and accept strobe (fires once per new stable pattern)
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1   <= 8'hFF;
      sync2   <= 8'hFF;
      cand    <= 8'h00;
      cnt     <= 4'd0;
      pattern <= BLANK_PAT;
      accept  <= 1'b0;
    end else begin
      sync1  <= seg_n;
      sync2  <= sync1;
      cand   <= seg;
      cnt    <= cnt_next;
      accept <= 1'b0;
      if (cnt_next == STABLE && seg != pattern) begin
        accept  <= 1'b1;
        pattern <= seg;
      end
    end
  end

endmodule

// File: rtl/fig8_seg_monitor.sv
// Figure-eight segment monitor: decodes filtered patterns, tracks lock, counts steps, measures period.
// Latency: seg_n settled before edge k -> step_valid high after edge k+2+STABLE_CYCLES.
// Backpressure: none; outputs are registered status and a one-cycle step strobe.
module fig8_seg_monitor
  import fig8_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int PERIOD_W      = 22
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          seg_n,
  output logic                step_valid,
  output logic [2:0]          step_idx,
  output logic                locked,
  output logic                seq_error,
  output logic [7:0]          step_count,
  output logic [PERIOD_W-1:0] period
);

  localparam logic [PERIOD_W-1:0] PERIOD_MAX = '1;
  localparam logic [PERIOD_W-1:0] PERIOD_ONE = PERIOD_W'(1);

  logic [7:0]          acc_pat;
  logic                acc;
  decode_t             dec;
  state_t              state;
  logic [PERIOD_W-1:0] timer;
  logic                first_done;
  logic                is_step;
  logic                is_succ;
  logic [2:0]          next_idx;

  seg_input_filter #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_filter (
    .clk    (clk),
    .reset  (reset),
    .seg_n  (seg_n),
    .pattern(acc_pat),
    .accept (acc)
  );

  assign dec      = decode_pat(acc_pat, step_idx);
  assign next_idx = step_idx + 3'd1;
  assign is_step  = acc && (dec.kind == PAT_STEP);
  assign is_succ  = (dec.idx == next_idx);

  // Lock FSM, step strobe, counters and inter-step timer, all registered
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      step_valid <= 1'b0;
      step_idx   <= 3'd0;
      locked     <= 1'b0;
      seq_error  <= 1'b0;
      step_count <= 8'd0;
      period     <= '0;
      timer      <= '0;
      first_done <= 1'b0;
    end else begin
      step_valid <= 1'b0;
      if (timer != PERIOD_MAX) begin
        timer <= timer + PERIOD_ONE;
      end

      // Any decodable step is reported and restarts the timer; the very first has no predecessor
      if (is_step) begin
        step_valid <= 1'b1;
        step_idx   <= dec.idx;
        timer      <= '0;
        first_done <= 1'b1;
        if (first_done) begin
          period <= (timer == PERIOD_MAX) ? PERIOD_MAX : timer + PERIOD_ONE;
        end
      end

      if (acc) begin
        case (state)
          IDLE: begin
            if (dec.kind == PAT_STEP) begin
              state <= ANCHOR;
            end
          end
          ANCHOR: begin
            if (dec.kind == PAT_STEP) begin
              if (is_succ) begin
                state      <= LOCKED;
                locked     <= 1'b1;
                step_count <= step_count + 8'd1;
              end
            end else if (dec.kind == PAT_BLANK || dec.kind == PAT_INVALID) begin
              state <= IDLE;
            end
          end
          LOCKED: begin
            if (dec.kind == PAT_STEP) begin
              if (is_succ) begin
                step_count <= step_count + 8'd1;
              end else begin
                seq_error <= 1'b1;
                locked    <= 1'b0;
                state     <= ANCHOR;
              end
            end else if (dec.kind == PAT_BLANK) begin
              // A blank is a pause, not a fault
              locked <= 1'b0;
              state  <= IDLE;
            end else begin
              seq_error <= 1'b1;
              locked    <= 1'b0;
              state     <= IDLE;
            end
          end
          default: begin
            state  <= IDLE;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fig8_seg_monitor.sv
// Directed bench for fig8_seg_monitor: reset, full lap, glitch, skip, ambiguous g, blank, mid-run reset.
// Inputs change #1 after the rising edge; outputs are sampled at the same point.
// Expected values are hand-derived constants.
module tb_fig8_seg_monitor;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  seg_n;
  logic        step_valid;
  logic [2:0]  step_idx;
  logic        locked;
  logic        seq_error;
  logic [7:0]  step_count;
  logic [21:0] period;

  int tests  = 0;
  int failed = 0;

  int          pulses;
  int          first_at;
  logic [2:0]  idx_at;
  logic [21:0] per_at;
  int          gp;

  logic [7:0] loop_pat [9] = '{8'h01, 8'h02, 8'h40, 8'h10, 8'h08, 8'h04, 8'h40, 8'h20, 8'h01};

  always #5 clk = ~clk;

  fig8_seg_monitor dut (
    .clk       (clk),
    .reset     (reset),
    .seg_n     (seg_n),
    .step_valid(step_valid),
    .step_idx  (step_idx),
    .locked    (locked),
    .seq_error (seq_error),
    .step_count(step_count),
    .period    (period)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Hold an active-high pattern for n cycles, recording step strobes seen along the way
  task automatic drive(input logic [7:0] pat, input int n);
    seg_n    = ~pat;
    pulses   = 0;
    first_at = -1;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk);
      #1;
      if (step_valid === 1'b1) begin
        pulses++;
        if (first_at < 0) first_at = i;
        idx_at = step_idx;
        per_at = period;
      end
    end
  endtask

  initial begin
    idx_at = 3'd0;
    per_at = '0;

    // Reset with random segment activity
    reset = 1'b1;
    seg_n = 8'($urandom);
    repeat (3) begin
      @(posedge clk);
      #1;
      seg_n = 8'($urandom);
    end
    check("rst_step_valid", step_valid, 0);
    check("rst_step_idx",   step_idx,   0);
    check("rst_locked",     locked,     0);
    check("rst_seq_error",  seq_error,  0);
    check("rst_step_count", step_count, 0);
    check("rst_period",     period,     0);
    reset = 1'b0;
    drive(8'h00, 20);
    check("rst_release_no_step", pulses, 0);

    // One full lap plus the wrap back to a, each pattern held 4097 cycles
    for (int i = 0; i < 9; i++) begin
      drive(loop_pat[i], 4097);
      check("loop_pulses", pulses, 1);
      check("loop_idx", idx_at, i % 8);
      check("loop_locked", locked, (i >= 1));
      if (i == 0) begin
        check("loop_latency", first_at, 7);
        check("loop_first_period", per_at, 0);
      end else begin
        check("loop_period", per_at, 4097);
      end
    end
    check("loop_step_count", step_count, 8);
    check("loop_seq_error", seq_error, 0);

    // Walk on to idx 3 with a shorter hold
    drive(8'h02, 30);
    drive(8'h40, 30);
    check("walk_g_idx", idx_at, 2);
    drive(8'h10, 30);
    check("walk_idx", idx_at, 3);
    check("walk_period", per_at, 30);
    check("walk_count", step_count, 11);

    // Two-cycle glitch to d, then back to e
    drive(8'h08, 2);
    gp = pulses;
    drive(8'h10, 20);
    gp += pulses;
    check("glitch_pulses", gp, 0);
    check("glitch_idx", step_idx, 3);
    check("glitch_err", seq_error, 0);
    check("glitch_locked", locked, 1);

    // Skip from e straight to c, then recover through g
    drive(8'h04, 30);
    check("skip_pulses", pulses, 1);
    check("skip_idx", idx_at, 5);
    check("skip_err", seq_error, 1);
    check("skip_locked", locked, 0);
    drive(8'h40, 30);
    check("skip_g_idx", idx_at, 6);
    check("skip_relock", locked, 1);
    check("skip_err_sticky", seq_error, 1);
    check("skip_count", step_count, 12);

    // Reset clears the sticky error
    reset = 1'b1;
    seg_n = 8'hFF;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    check("rst2_err", seq_error, 0);
    check("rst2_count", step_count, 0);

    // Ambiguous g from IDLE is ignored
    drive(8'h40, 30);
    check("amb_g_pulses", pulses, 0);
    check("amb_g_locked", locked, 0);
    drive(8'h20, 30);
    check("amb_f_pulses", pulses, 1);
    check("amb_f_idx", idx_at, 7);
    check("amb_f_period", per_at, 0);
    check("amb_f_locked", locked, 0);
    drive(8'h01, 30);
    check("amb_a_idx", idx_at, 0);
    check("amb_a_locked", locked, 1);
    check("amb_a_period", per_at, 30);
    check("amb_a_count", step_count, 1);

    // Blank while locked is a pause
    drive(8'h00, 30);
    check("blank_pulses", pulses, 0);
    check("blank_locked", locked, 0);
    check("blank_err", seq_error, 0);
    drive(8'h01, 30);
    check("resume_a_pulses", pulses, 1);
    check("resume_a_locked", locked, 0);
    drive(8'h02, 30);
    check("resume_b_idx", idx_at, 1);
    check("resume_b_locked", locked, 1);
    check("resume_count", step_count, 2);

    // Reset in the middle of a stability window discards the partial count
    drive(8'h40, 3);
    gp = pulses;
    reset = 1'b1;
    seg_n = 8'hFF;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    drive(8'h00, 30);
    gp += pulses;
    check("midrst_pulses", gp, 0);
    check("midrst_locked", locked, 0);
    check("midrst_idx", step_idx, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
